// File: rtl/cache_pkg.sv
// Shared constants and enumerated types for the cache-to-memory arbiter.
package cache_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int BLOCK_WORDS = 4;
    localparam int OFFSET_BITS = $clog2(BLOCK_WORDS) + 2;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, one-bit last-grant memory.
module rr_arbiter2
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output owner_t     gnt_o,
    output logic       valid_o
);

    owner_t last_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_o   = OWN_I;
        valid_o = |req_i;
        case (req_i)
            2'b01:   gnt_o = OWN_I;
            2'b10:   gnt_o = OWN_D;
            2'b11:   gnt_o = (last_q == OWN_I) ? OWN_D : OWN_I;
            default: gnt_o = OWN_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_I;
        end else if (update_i && valid_o) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache block refills and D-cache refills/writes,
// issuing one beat at a time with round-robin ownership and registered outputs.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = cache_pkg::DATA_WIDTH,
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    import cache_pkg::*;

    localparam int BEAT_BITS = $clog2(BLOCK_WORDS);
    localparam int BLK_OFF   = BEAT_BITS + 2;
    localparam logic [BEAT_BITS-1:0]  LAST_BEAT  = BEAT_BITS'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] READ_MASK  = {{(ADDR_WIDTH-BLK_OFF){1'b1}}, {BLK_OFF{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] WRITE_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    arb_state_t            state_q;
    logic [BEAT_BITS-1:0]  beat_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  mem_req_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  i_rvalid_q, i_done_q, d_rvalid_q, d_done_q;
    logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

    owner_t                arb_gnt;
    logic                  arb_valid;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [BEAT_BITS-1:0]  beat_d;
    logic                  last_beat;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({d_req, i_req}),
        .update_i (state_q == IDLE),
        .gnt_o    (arb_gnt),
        .valid_o  (arb_valid)
    );

    // Block alignment guarantees the offset add never carries past the block.
    assign mem_addr_d = base_q + ADDR_WIDTH'({beat_q, 2'b00});
    assign beat_d     = beat_q + 1'b1;
    assign last_beat  = we_q || (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            base_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make these single-cycle pulses; a later <= in this block wins.
            i_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_done_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        beat_q <= '0;
                        if (arb_gnt == OWN_D) begin
                            state_q <= GRANT_D;
                            base_q  <= d_addr & (d_we ? WRITE_MASK : READ_MASK);
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                        end else begin
                            state_q <= GRANT_I;
                            base_q  <= i_addr & READ_MASK;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end
                end

                GRANT_I, GRANT_D: begin
                    if (!mem_req_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= we_q;
                        mem_addr_q  <= mem_addr_d;
                        mem_wdata_q <= wdata_q;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!we_q) begin
                            if (state_q == GRANT_I) begin
                                i_rvalid_q <= 1'b1;
                                i_rdata_q  <= mem_rdata;
                            end else begin
                                d_rvalid_q <= 1'b1;
                                d_rdata_q  <= mem_rdata;
                            end
                        end
                        if (last_beat) begin
                            state_q <= IDLE;
                            if (state_q == GRANT_I) i_done_q <= 1'b1;
                            else                    d_done_q <= 1'b1;
                        end else begin
                            beat_q <= beat_d;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter with a delayed-ack memory model.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_rvalid, i_done, d_rvalid, d_done;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    cache_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks after ack_delay extra cycles of mem_req; rdata = base + word index.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          hold;
    } beat_t;

    int          ack_delay   = 1;
    logic [31:0] rdata_base  = 32'h0;
    int          hold_cnt    = 0;
    beat_t       beats[$];
    int          rises[$];
    logic [31:0] i_rv_data[$], d_rv_data[$];
    int          i_rv_cyc[$], i_done_cyc[$], d_done_cyc[$];
    byte         order[$];
    int          both_rv = 0;
    logic        prev_req = 1'b0;

    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack  = 1'b0;
            hold_cnt = 0;
        end else if (mem_req) begin
            hold_cnt++;
            if (hold_cnt > ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_base + ((mem_addr >> 2) & 32'h3);
                beats.push_back('{mem_addr, mem_we, mem_wdata, hold_cnt});
            end
        end else begin
            hold_cnt = 0;
        end
        if (mem_req && !prev_req) rises.push_back(cyc);
        prev_req = mem_req;
        if (i_rvalid) begin i_rv_data.push_back(i_rdata); i_rv_cyc.push_back(cyc); end
        if (d_rvalid) d_rv_data.push_back(d_rdata);
        if (i_done) begin i_done_cyc.push_back(cyc); order.push_back("I"); end
        if (d_done) begin d_done_cyc.push_back(cyc); order.push_back("D"); end
        if (i_rvalid && d_rvalid) both_rv++;
    end

    task automatic clear_logs();
        beats.delete(); rises.delete(); i_rv_data.delete(); d_rv_data.delete();
        i_rv_cyc.delete(); i_done_cyc.delete(); d_done_cyc.delete(); order.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_done(input bit is_d, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (is_d ? d_done : i_done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        apply_reset();
        outs = {mem_req, mem_we, i_rvalid, i_done, d_rvalid, d_done} | mem_addr | mem_wdata | i_rdata | d_rdata;
        n_checks++;
        if (outs !== 32'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
        n_checks++;
        if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    endtask

    task automatic test_icache_only();
        bit ok;
        apply_reset();
        ack_delay = 1; rdata_base = 32'hA0;
        i_addr = 32'h0000_1238; i_req = 1'b1;
        wait_done(1'b0, 60, ok);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL icache_done_timeout: got none want i_done"); end
        n_checks++;
        if (beats.size() != 4) begin n_fail++; $display("FAIL icache_beats: got %0d want 4", beats.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (beats[k].addr !== 32'h1230 + 32'(4*k) || beats[k].we !== 1'b0) begin
                n_fail++; $display("FAIL icache_addr%0d: got %h we=%b want %h we=0", k, beats[k].addr, beats[k].we, 32'h1230 + 32'(4*k));
            end
        end
        n_checks++;
        if (i_rv_data.size() != 4) begin n_fail++; $display("FAIL icache_rvalid_count: got %0d want 4", i_rv_data.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (i_rv_data[k] !== 32'hA0 + 32'(k)) begin n_fail++; $display("FAIL icache_rdata%0d: got %h want %h", k, i_rv_data[k], 32'hA0 + 32'(k)); end
            end
            n_checks++;
            if (i_done_cyc.size() != 1 || i_done_cyc[0] != i_rv_cyc[3]) begin
                n_fail++; $display("FAIL icache_done_align: got %0d dones want 1 at cycle %0d", i_done_cyc.size(), i_rv_cyc[3]);
            end
        end
        n_checks++;
        if (rises.size() < 2 || rises[1] - rises[0] != 3) begin n_fail++; $display("FAIL icache_beat_gap: got rises=%0d want spacing 3", rises.size()); end
        n_checks++;
        if (d_rv_data.size() + d_done_cyc.size() != 0) begin n_fail++; $display("FAIL icache_d_quiet: got %0d d events want 0", d_rv_data.size() + d_done_cyc.size()); end
    endtask

    task automatic test_simultaneous();
        bit ok_d, ok_i;
        apply_reset();
        ack_delay = 1; rdata_base = 32'hB0;
        i_addr = 32'h1238; d_addr = 32'h2000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        wait_done(1'b1, 60, ok_d);
        d_req = 1'b0;
        wait_done(1'b0, 60, ok_i);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (!(ok_d && ok_i)) begin n_fail++; $display("FAIL simul_timeout: got d=%b i=%b want both done", ok_d, ok_i); end
        n_checks++;
        if (beats.size() != 8) begin n_fail++; $display("FAIL simul_beats: got %0d want 8", beats.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (beats[k].addr !== 32'h2000 + 32'(4*k) || beats[k+4].addr !== 32'h1230 + 32'(4*k)) begin
                n_fail++; $display("FAIL simul_order%0d: got %h/%h want %h/%h", k, beats[k].addr, beats[k+4].addr, 32'h2000 + 32'(4*k), 32'h1230 + 32'(4*k));
            end
        end
        n_checks++;
        if (d_rv_data.size() != 4 || d_rv_data[3] !== 32'hB3) begin n_fail++; $display("FAIL simul_drdata: got %0d words want 4 ending B3", d_rv_data.size()); end
        n_checks++;
        if (rises.size() < 5 || d_done_cyc.size() != 1 || rises[4] - d_done_cyc[0] != 2) begin
            n_fail++; $display("FAIL simul_handover_gap: got rises=%0d dones=%0d want gap 2", rises.size(), d_done_cyc.size());
        end
    endtask

    task automatic test_fairness();
        bit   ok;
        byte  exp_order[4] = '{"D", "I", "D", "I"};
        apply_reset();
        ack_delay = 1; rdata_base = 32'hC0;
        i_addr = 32'h1000; d_addr = 32'h2040; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            ok = 1'b0;
            for (int n = 0; n < 60 && !ok; n++) begin
                @(negedge clk);
                if (i_done || d_done) ok = 1'b1;
            end
            if (t == 3 || !ok) begin i_req = 1'b0; d_req = 1'b0; end
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL fair_timeout%0d: got none want done", t); break; end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (order.size() != 4) begin n_fail++; $display("FAIL fair_count: got %0d want 4", order.size()); end
        else for (int t = 0; t < 4; t++) begin
            n_checks++;
            if (order[t] != exp_order[t]) begin n_fail++; $display("FAIL fair_order%0d: got %c want %c", t, order[t], exp_order[t]); end
        end
    endtask

    task automatic test_dcache_write();
        bit ok;
        apply_reset();
        ack_delay = 3;
        d_we = 1'b1; d_addr = 32'h3006; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        wait_done(1'b1, 60, ok);
        d_req = 1'b0; d_we = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wr_timeout: got none want d_done"); end
        n_checks++;
        if (beats.size() != 1) begin n_fail++; $display("FAIL wr_beats: got %0d want 1", beats.size()); end
        else begin
            n_checks++;
            if (beats[0].addr !== 32'h3004 || beats[0].we !== 1'b1 || beats[0].wdata !== 32'hDEAD_BEEF) begin
                n_fail++; $display("FAIL wr_beat: got %h we=%b %h want 3004 we=1 deadbeef", beats[0].addr, beats[0].we, beats[0].wdata);
            end
            n_checks++;
            if (beats[0].hold != 4) begin n_fail++; $display("FAIL wr_hold: got %0d want 4", beats[0].hold); end
        end
        n_checks++;
        if (d_done_cyc.size() != 1 || d_rv_data.size() != 0) begin
            n_fail++; $display("FAIL wr_pulses: got done=%0d rvalid=%0d want 1/0", d_done_cyc.size(), d_rv_data.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int          nrv = 0;
        bit          ok;
        logic [31:0] outs;
        apply_reset();
        ack_delay = 1; rdata_base = 32'hE0;
        i_addr = 32'h1238; i_req = 1'b1;
        for (int n = 0; n < 60 && nrv < 2; n++) begin
            @(negedge clk);
            if (i_rvalid) nrv++;
        end
        reset = 1'b1; i_req = 1'b0;
        @(negedge clk);
        outs = {mem_req, mem_we, i_rvalid, i_done, d_rvalid, d_done} | mem_addr | mem_wdata | i_rdata | d_rdata;
        n_checks++;
        if (nrv != 2 || outs !== 32'h0) begin n_fail++; $display("FAIL midrst_outputs: got rv=%0d outs=%h want 2/0", nrv, outs); end
        n_checks++;
        if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want IDLE", dut.state_q); end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (i_done_cyc.size() != 0 || beats.size() != 2) begin
            n_fail++; $display("FAIL midrst_abort: got dones=%0d beats=%0d want 0/2", i_done_cyc.size(), beats.size());
        end
        clear_logs();
        d_addr = 32'h2000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (i_done || d_done) ok = 1'b1;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || order.size() != 1 || order[0] != "D") begin
            n_fail++; $display("FAIL midrst_first_tie: got ok=%b dones=%0d want one D", ok, order.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        ack_delay = 1; rdata_base = 32'hF0;
        i_addr = 32'hFFFF_FFF4; i_req = 1'b1;
        wait_done(1'b0, 60, ok);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || beats.size() != 4) begin n_fail++; $display("FAIL wrap_beats: got ok=%b n=%0d want 4", ok, beats.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (beats[k].addr !== 32'hFFFF_FFF0 + 32'(4*k)) begin
                n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", k, beats[k].addr, 32'hFFFF_FFF0 + 32'(4*k));
            end
        end
        n_checks++;
        if (i_rv_cyc.size() != 4 || i_done_cyc.size() != 1 || i_done_cyc[0] != i_rv_cyc[3]) begin
            n_fail++; $display("FAIL wrap_done: got rv=%0d done=%0d want 4/1 aligned", i_rv_cyc.size(), i_done_cyc.size());
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (both_rv != 0) begin n_fail++; $display("FAIL rvalid_exclusive: got %0d overlaps want 0", both_rv); end
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_icache_only();
        test_simultaneous();
        test_fairness();
        test_dcache_write();
        test_reset_mid_burst();
        test_wrap();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
